uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 26 ++
 rtl/uart_rx.sv | 130 +++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Signal bundle between a UART receiver and its surroundings: serial line and baud
// tick in, received byte, status strobes and FSM debug state out.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  // No backpressure: O_rx_done and O_frame_err are valid-only strobes, one I_sys_clk
  // cycle wide; the consumer must take O_rx_data in the O_rx_done cycle or read it
  // later, because it holds until the next good frame.
  logic                 I_baud_tick;
  logic                 I_rx;
  logic [DATA_BITS-1:0] O_rx_data;
  logic                 O_rx_done;
  logic                 O_frame_err;
  logic                 O_busy;
  logic [2:0]           O_dbg_state;

  modport master (
    output I_baud_tick, I_rx,
    input  O_rx_data, O_rx_done, O_frame_err, O_busy, O_dbg_state
  );

  modport slave (
    input  I_baud_tick, I_rx,
    output O_rx_data, O_rx_done, O_frame_err, O_busy, O_dbg_state
  );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: mid-bit sampling, start-glitch rejection, framing
// error detection and a BREAK state that waits out a held-low line.
module uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int SB_TICKS  = 16
) (
  input  logic      I_sys_clk,
  input  logic      I_rst,
  uart_rx_if.slave  bus
);

  localparam int TW = (SB_TICKS > 16) ? 5 : 4;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  logic                 rx_meta_q, rx_s_q;
  state_t               state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Leaving IDLE needs no tick; a tick in this cycle is deliberately ignored.
        if (!rx_s_q) begin
          state_d = ST_START;
          tick_d  = '0;
        end
      end
      ST_START: begin
        if (bus.I_baud_tick) begin
          if (tick_q == TW'(7)) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rx_s_q ? ST_IDLE : ST_DATA;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      ST_DATA: begin
        if (bus.I_baud_tick) begin
          if (tick_q == TW'(15)) begin
            tick_d  = '0;
            shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
            if (bit_q == BW'(DATA_BITS - 1)) begin
              bit_d   = '0;
              state_d = ST_STOP;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      ST_STOP: begin
        if (bus.I_baud_tick) begin
          if (tick_q == TW'(SB_TICKS - 1)) begin
            tick_d = '0;
            if (rx_s_q) begin
              data_d  = shreg_q;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_BREAK;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      ST_BREAK: begin
        // Only a return to idle-high re-arms the receiver, so a held-low line is one error.
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_sys_clk or posedge I_rst) begin
    if (I_rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= ST_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= bus.I_rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
    end
  end

  assign bus.O_rx_data   = data_q;
  assign bus.O_rx_done   = done_q;
  assign bus.O_frame_err = ferr_q;
  assign bus.O_busy      = (state_q != ST_IDLE);
  assign bus.O_dbg_state = state_q;

endmodule
